mod2: RTL and testbench

// - Second stage of the Mod3 chain: takes the registered bit from Mod1 and delays it
//   by a fixed number of cycles before driving the Mod3 output.
// - Carries a fault-injection input that flips the data bit entering the pipeline.
// - A parallel clean shadow pipeline compares against the data path to detect

---
 rtl/mod2_pkg.sv | 30 +++
 rtl/mod2_sat_cnt.sv | 24 ++
 rtl/mod2.sv | 67 ++++++
 tb/tb_mod2.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mod2_pkg.sv
// Shared constants, stage type and helpers for the mod2 delay stage with
// fault injection and shadow-path fault detection.
package mod2_pkg;

  localparam int DEPTH_DEF = 2;
  localparam int CNT_W_DEF = 8;
  localparam int DEPTH_MAX = 16;
  localparam int CNT_W_MAX = 32;

  // One pipeline position: the (possibly faulted) data bit and its clean twin.
  typedef struct packed {
    logic data;
    logic shadow;
  } stage_t;

  localparam stage_t STAGE_CLR = '{data: 1'b0, shadow: 1'b0};

  // Value loaded into the head stage: injection flips only the data copy.
  function automatic stage_t stage_load(input logic bit_in, input logic inject);
    stage_t s;
    s.data   = bit_in ^ inject;
    s.shadow = bit_in;
    return s;
  endfunction

  function automatic logic stage_mismatch(input stage_t s);
    return s.data ^ s.shadow;
  endfunction

endpackage

// File: rtl/mod2_sat_cnt.sv
// Saturating up-counter with synchronous active-low clear; holds at all-ones
// instead of wrapping.
module mod2_sat_cnt #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  logic at_max;

  assign at_max = &cnt;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (inc && !at_max) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/mod2.sv
// Mod3 chain stage 2: delays the incoming bit by DEPTH registers, with an
// optional injected flip and a clean shadow pipeline that flags any mismatch.
module mod2
  import mod2_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             io_in02,
  input  logic             io_fin02,
  output logic             io_out02,
  output logic             io_fout02,
  output logic [CNT_W-1:0] io_fcnt02
);

  if (DEPTH < 1 || DEPTH > DEPTH_MAX) begin : g_bad_depth
    $error("mod2: DEPTH out of range 1..16");
  end
  if (CNT_W < 1 || CNT_W > CNT_W_MAX) begin : g_bad_cnt_w
    $error("mod2: CNT_W out of range 1..32");
  end

  // Data and shadow bits travel side by side so they stay cycle-aligned.
  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    stage_t q;
    if (i == 0) begin : g_head
      // NOTE: registered state uses non-blocking assignments so every stage
      // samples its predecessor's pre-edge value, independent of block order.
      always_ff @(posedge clk) begin
        // NOTE: each stage is cleared on reset; in-flight bits must be
        // discarded so the outputs read 0 right after reset.
        if (!reset_n) q <= STAGE_CLR;
        else          q <= stage_load(io_in02, io_fin02);
      end
    end else begin : g_body
      always_ff @(posedge clk) begin
        if (!reset_n) q <= STAGE_CLR;
        else          q <= g_stage[i-1].q;
      end
    end
  end

  stage_t tap;
  logic   mismatch;

  assign tap      = g_stage[DEPTH-1].q;
  assign io_out02 = tap.data;
  assign mismatch = stage_mismatch(tap);

  // Sticky: only reset clears the flag.
  always_ff @(posedge clk) begin
    if (!reset_n)      io_fout02 <= 1'b0;
    else if (mismatch) io_fout02 <= 1'b1;
  end

  mod2_sat_cnt #(
    .W (CNT_W)
  ) u_fcnt (
    .clk     (clk),
    .reset_n (reset_n),
    .inc     (mismatch),
    .cnt     (io_fcnt02)
  );

endmodule

// File: tb/tb_mod2.sv
// Directed and randomized bench for mod2: three instances (DEPTH/CNT_W =
// 2/8, 2/3, 4/8) share one stimulus stream and a behavioural reference model.
module tb_mod2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset_n = 1'b0;
  logic       io_in02 = 1'b0;
  logic       io_fin02 = 1'b0;

  logic       a_out, a_fout;
  logic [7:0] a_cnt;
  logic       b_out, b_fout;
  logic [2:0] b_cnt;
  logic       c_out, c_fout;
  logic [7:0] c_cnt;

  mod2 #(.DEPTH(2), .CNT_W(8)) u_a (
    .clk(clk), .reset_n(reset_n), .io_in02(io_in02), .io_fin02(io_fin02),
    .io_out02(a_out), .io_fout02(a_fout), .io_fcnt02(a_cnt)
  );
  mod2 #(.DEPTH(2), .CNT_W(3)) u_b (
    .clk(clk), .reset_n(reset_n), .io_in02(io_in02), .io_fin02(io_fin02),
    .io_out02(b_out), .io_fout02(b_fout), .io_fcnt02(b_cnt)
  );
  mod2 #(.DEPTH(4), .CNT_W(8)) u_c (
    .clk(clk), .reset_n(reset_n), .io_in02(io_in02), .io_fin02(io_fin02),
    .io_out02(c_out), .io_fout02(c_fout), .io_fcnt02(c_cnt)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state, one slot per instance.
  bit [15:0]   md [3];
  bit [15:0]   ms [3];
  int unsigned mcnt [3];
  bit          mflag [3];

  function automatic int dep(input int k);
    return (k == 2) ? 4 : 2;
  endfunction

  function automatic int unsigned cmax(input int k);
    return (k == 1) ? 7 : 255;
  endfunction

  function automatic logic act_out(input int k);
    case (k)
      0:       return a_out;
      1:       return b_out;
      default: return c_out;
    endcase
  endfunction

  function automatic logic act_fout(input int k);
    case (k)
      0:       return a_fout;
      1:       return b_fout;
      default: return c_fout;
    endcase
  endfunction

  function automatic int unsigned act_cnt(input int k);
    case (k)
      0:       return int'(a_cnt);
      1:       return int'(b_cnt);
      default: return int'(c_cnt);
    endcase
  endfunction

  // Drive inputs, advance one rising edge (model too), settle at the falling edge.
  task automatic step(input logic r, input logic x, input logic f);
    reset_n  = r;
    io_in02  = x;
    io_fin02 = f;
    @(posedge clk);
    for (int k = 0; k < 3; k++) begin
      if (!r) begin
        md[k] = '0; ms[k] = '0; mcnt[k] = 0; mflag[k] = 1'b0;
      end else begin
        if (md[k][dep(k)-1] != ms[k][dep(k)-1]) begin
          mflag[k] = 1'b1;
          if (mcnt[k] < cmax(k)) mcnt[k] = mcnt[k] + 1;
        end
        md[k] = {md[k][14:0], x ^ f};
        ms[k] = {ms[k][14:0], x};
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    logic a_exp [4];
    logic c_exp [4];
    a_exp = '{1'b0, 1'b1, 1'b1, 1'b1};
    c_exp = '{1'b0, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1, 1'b0);
      checks++;
      if ({a_out, a_fout, a_cnt, b_out, b_fout, b_cnt, c_out, c_fout, c_cnt} !== 23'd0) begin
        errors++;
        $display("FAIL reset_hold cyc%0d: got a=%b/%b/%0d b=%b/%b/%0d c=%b/%b/%0d want all 0",
                 i, a_out, a_fout, a_cnt, b_out, b_fout, b_cnt, c_out, c_fout, c_cnt);
      end
    end
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b1, 1'b0);
      checks++;
      if ({a_out, c_out, a_fout, c_fout, a_cnt, c_cnt} !== {a_exp[i], c_exp[i], 18'd0}) begin
        errors++;
        $display("FAIL reset_release cyc%0d: got a_out=%b c_out=%b flags=%b%b cnt=%0d/%0d want %b %b 00 0/0",
                 i, a_out, c_out, a_fout, c_fout, a_cnt, c_cnt, a_exp[i], c_exp[i]);
      end
    end
  endtask

  task automatic test_latency();
    logic pat [6];
    logic exp_out [6];
    pat     = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    exp_out = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      step(1'b1, pat[i], 1'b0);
      checks++;
      if (a_out !== exp_out[i]) begin
        errors++;
        $display("FAIL latency cyc%0d: got out=%b want %b", i, a_out, exp_out[i]);
      end
    end
    checks++;
    if ({a_fout, a_cnt} !== 9'd0) begin
      errors++;
      $display("FAIL latency_flag: got flag=%b cnt=%0d want 0 0", a_fout, a_cnt);
    end
  endtask

  task automatic test_single_fault();
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b1);   // edge E: head takes the flipped bit
    checks++;
    if ({a_out, a_fout, a_cnt} !== {1'b1, 1'b0, 8'd0}) begin
      errors++;
      $display("FAIL fault_E: got out=%b flag=%b cnt=%0d want 1 0 0", a_out, a_fout, a_cnt);
    end
    step(1'b1, 1'b1, 1'b0);   // E+1: faulted bit reaches the output
    checks++;
    if ({a_out, a_fout, a_cnt} !== {1'b0, 1'b0, 8'd0}) begin
      errors++;
      $display("FAIL fault_E1: got out=%b flag=%b cnt=%0d want 0 0 0", a_out, a_fout, a_cnt);
    end
    step(1'b1, 1'b1, 1'b0);   // E+2: flag and count together
    checks++;
    if ({a_out, a_fout, a_cnt, b_fout, b_cnt} !== {1'b1, 1'b1, 8'd1, 1'b1, 3'd1}) begin
      errors++;
      $display("FAIL fault_E2: got out=%b flag=%b cnt=%0d b=%b/%0d want 1 1 1 b=1/1",
               a_out, a_fout, a_cnt, b_fout, b_cnt);
    end
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0);
    checks++;
    if ({a_fout, a_cnt, b_fout, b_cnt, c_fout, c_cnt, c_out} !==
        {1'b1, 8'd1, 1'b1, 3'd1, 1'b1, 8'd1, 1'b1}) begin
      errors++;
      $display("FAIL fault_hold: got a=%b/%0d b=%b/%0d c=%b/%0d c_out=%b want 1/1 1/1 1/1 1",
               a_fout, a_cnt, b_fout, b_cnt, c_fout, c_cnt, c_out);
    end
  endtask

  task automatic test_saturation();
    for (int i = 1; i <= 20; i++) begin
      step(1'b1, logic'(i[0]), 1'b1);
      if (i == 7) begin
        checks++;
        if (b_cnt !== 3'd6) begin
          errors++;
          $display("FAIL sat_before: got cnt=%0d want 6", b_cnt);
        end
      end else if (i == 8) begin
        checks++;
        if (b_cnt !== 3'd7) begin
          errors++;
          $display("FAIL sat_reach: got cnt=%0d want 7", b_cnt);
        end
      end
    end
    checks++;
    if ({b_fout, b_cnt, a_cnt, c_cnt} !== {1'b1, 3'd7, 8'd19, 8'd17}) begin
      errors++;
      $display("FAIL sat_hold: got b=%b/%0d a_cnt=%0d c_cnt=%0d want 1/7 19 17",
               b_fout, b_cnt, a_cnt, c_cnt);
    end
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0);
    checks++;
    if ({a_fout, a_cnt, b_fout, b_cnt, c_fout, c_cnt} !==
        {1'b1, 8'd21, 1'b1, 3'd7, 1'b1, 8'd21}) begin
      errors++;
      $display("FAIL sat_drain: got a=%b/%0d b=%b/%0d c=%b/%0d want 1/21 1/7 1/21",
               a_fout, a_cnt, b_fout, b_cnt, c_fout, c_cnt);
    end
  endtask

  task automatic test_reset_mid();
    step(1'b1, 1'b1, 1'b1);   // leave a fault in flight
    step(1'b0, 1'b1, 1'b1);   // injection during reset must be ignored
    checks++;
    if ({a_out, a_fout, a_cnt, b_out, b_fout, b_cnt, c_out, c_fout, c_cnt} !== 23'd0) begin
      errors++;
      $display("FAIL reset_mid: got a=%b/%b/%0d b=%b/%b/%0d c=%b/%b/%0d want all 0",
               a_out, a_fout, a_cnt, b_out, b_fout, b_cnt, c_out, c_fout, c_cnt);
    end
    for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 1'b0);
    checks++;
    if ({a_out, a_fout, a_cnt, c_out, c_fout, c_cnt} !== {1'b1, 1'b0, 8'd0, 1'b1, 1'b0, 8'd0}) begin
      errors++;
      $display("FAIL reset_mid_clean: got a=%b/%b/%0d c=%b/%b/%0d want 1/0/0 1/0/0",
               a_out, a_fout, a_cnt, c_out, c_fout, c_cnt);
    end
  endtask

  task automatic test_random();
    logic r, x, f;
    for (int n = 0; n < 10000; n++) begin
      r = ($urandom_range(0, 299) != 0);
      x = logic'($urandom_range(0, 1));
      f = (n < 5000) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 63) == 0);
      step(r, x, f);
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (act_out(k) !== md[k][dep(k)-1] || act_fout(k) !== mflag[k] ||
            act_cnt(k) !== mcnt[k]) begin
          errors++;
          $display("FAIL random inst%0d cyc%0d: got %b/%b/%0d want %b/%b/%0d",
                   k, n, act_out(k), act_fout(k), act_cnt(k),
                   md[k][dep(k)-1], mflag[k], mcnt[k]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_single_fault();
    test_saturation();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
